cache_mem_responder: RTL and testbench

Main-memory responder for the cache's memory-side request interface. It accepts one word-sized read or write request per handshake, waits a programmable latency, performs the RAM access, then pulses a one-cycle ready with the response data. It sits between the instruction cache miss path (Allocate/WriteBack) and the backing word-addressed RAM, and serves as both the synthesizable memory and the simulation memory model.

---
 rtl/cache_mem_responder_if.sv | 25 ++
 rtl/cache_mem_responder.sv | 120 ++++++++++++
 tb/tb_cache_mem_responder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_responder_if.sv
// Memory-side request bus between the instruction cache miss path and its backing RAM.
// master = cache (issues requests), slave = memory responder.
interface cache_mem_responder_if;
  logic [31:0] mem_req_addr;
  logic        mem_req_valid;
  logic        mem_req_wr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_req_data;
  logic        mem_req_ready;
  logic        mem_req_err;

  // Handshake: the master raises mem_req_valid with addr/wr/wr_data and holds
  // them until it sees mem_req_ready. The slave captures the request on the first
  // edge at which it is idle and valid is high. It then pulses mem_req_ready for
  // exactly one cycle, with mem_req_data/mem_req_err valid only during that pulse.
  modport master (
    output mem_req_addr, mem_req_valid, mem_req_wr, mem_wr_data,
    input  mem_req_data, mem_req_ready, mem_req_err
  );

  modport slave (
    input  mem_req_addr, mem_req_valid, mem_req_wr, mem_wr_data,
    output mem_req_data, mem_req_ready, mem_req_err
  );
endinterface

// File: rtl/cache_mem_responder.sv
// Word-addressed main-memory responder with programmable access latency.
// Optional macro MEM_RANGE_CHK_EN: flag and suppress accesses above the RAM depth.
module cache_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_mem_responder_if.slave  mem,
  output logic [1:0]            o_dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_wr;
  logic [31:0]           r_wr_data;
  logic                  r_oob;
  logic                  r_ready;
  logic [31:0]           r_data;
  logic                  r_err;

  // Contents are not touched by reset; they start at zero.
  logic [31:0] r_mem [DEPTH] = '{default: 32'h0};

  logic [DEPTH_LOG2-1:0] w_idx_in;
  logic                  w_oob_in;
  logic                  w_done;
  logic                  w_commit;
  logic                  w_unused;

  assign w_idx_in = mem.mem_req_addr[DEPTH_LOG2+1:2];

`ifdef MEM_RANGE_CHK_EN
  assign w_oob_in = |mem.mem_req_addr[31:DEPTH_LOG2+2];
  assign w_unused = ^mem.mem_req_addr[1:0];
  assign mem.mem_req_err = r_err;
`else
  // Upper address bits are dropped, so addresses alias modulo the RAM size.
  assign w_oob_in = 1'b0;
  assign w_unused = ^{mem.mem_req_addr[1:0], mem.mem_req_addr[31:DEPTH_LOG2+2], r_err};
  assign mem.mem_req_err = 1'b0;
`endif

  assign w_done   = (r_state == ST_BUSY) && (r_cnt == '0);
  assign w_commit = w_done && r_wr && !r_oob && !rst;

  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_idx] <= r_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_wr      <= 1'b0;
      r_wr_data <= 32'h0;
      r_oob     <= 1'b0;
      r_ready   <= 1'b0;
      r_data    <= 32'h0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mem.mem_req_valid) begin
            r_idx     <= w_idx_in;
            r_wr      <= mem.mem_req_wr;
            r_wr_data <= mem.mem_wr_data;
            r_oob     <= w_oob_in;
            r_cnt     <= CNT_LOAD;
            r_state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            // Writes echo their data; rejected accesses return zero.
            r_ready <= 1'b1;
            r_err   <= r_oob;
            if (r_oob) begin
              r_data <= 32'h0;
            end else if (r_wr) begin
              r_data <= r_wr_data;
            end else begin
              r_data <= r_mem[r_idx];
            end
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_ready <= 1'b0;
          r_data  <= 32'h0;
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem.mem_req_ready = r_ready;
  assign mem.mem_req_data  = r_data;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: table of single transactions plus
// hand-written sequences for hold/back-to-back/reset/alias corner cases.
module tb_cache_mem_responder;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state1;

  cache_mem_responder_if bus ();
  cache_mem_responder_if bus1 ();

  cache_mem_responder #(.DEPTH_LOG2(10), .LATENCY(4), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .mem(bus.slave), .o_dbg_state(dbg_state)
  );

  cache_mem_responder #(.DEPTH_LOG2(10), .LATENCY(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .mem(bus1.slave), .o_dbg_state(dbg_state1)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request on the LATENCY=4 instance; returns data, err and cycles to ready.
  task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                        output logic [31:0] rd, output logic re, output int lat);
    @(negedge clk);
    bus.mem_req_addr  = a;
    bus.mem_req_wr    = w;
    bus.mem_wr_data   = d;
    bus.mem_req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_req_valid = 1'b0;
    lat = -1;
    rd  = 32'hxxxx_xxxx;
    re  = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req_ready) begin
        lat = k;
        rd  = bus.mem_req_data;
        re  = bus.mem_req_err;
        break;
      end
    end
    @(posedge clk);
    #1;
    check("pulse_ready_drop", {31'b0, bus.mem_req_ready}, 32'h0);
    check("pulse_data_clear", bus.mem_req_data, 32'h0);
  endtask

  logic [31:0] rd;
  logic        re;
  int          lat;
  int          t_rdy[2];
  logic [31:0] d_rdy[2];
  int          n_rdy;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0010, 1'b0, 32'h0,         32'h0000_0000, 1'b0};
    vecs[1] = '{32'h0000_0040, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
    vecs[2] = '{32'h0000_0040, 1'b0, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[3] = '{32'h0000_0008, 1'b1, 32'h1111_2222, 32'h1111_2222, 1'b0};
    vecs[4] = '{32'h0000_0008, 1'b0, 32'h0,         32'h1111_2222, 1'b0};
    vecs[5] = '{32'h0000_0000, 1'b0, 32'h0,         32'h0000_0000, 1'b0};
    vecs[6] = '{32'h0000_0FFC, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[7] = '{32'h0000_0FFE, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0};

    bus.mem_req_addr   = 32'h0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_req_wr     = 1'b0;
    bus.mem_wr_data    = 32'h0;
    bus1.mem_req_addr  = 32'h0;
    bus1.mem_req_valid = 1'b0;
    bus1.mem_req_wr    = 1'b0;
    bus1.mem_wr_data   = 32'h0;

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, bus.mem_req_ready}, 32'h0);
    check("rst_data",  bus.mem_req_data, 32'h0);
    check("rst_err",   {31'b0, bus.mem_req_err}, 32'h0);
    check("rst_state", {30'b0, dbg_state}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // table-driven single transactions
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(vecs[i].exp_data);
      do_req(vecs[i].addr, vecs[i].wr, vecs[i].wdata, rd, re, lat);
      check($sformatf("vec%0d_data", i), rd, exp_q.pop_front());
      check($sformatf("vec%0d_err", i), {31'b0, re}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_lat", i), lat, 32'd4);
    end

    // inputs changed during BUSY must be ignored
    @(negedge clk);
    bus.mem_req_addr  = 32'h0000_0008;
    bus.mem_req_wr    = 1'b0;
    bus.mem_req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_addr  = 32'h0000_000C;
    bus.mem_req_wr    = 1'b1;
    bus.mem_wr_data   = 32'hBADB_AD00;
    lat = -1;
    rd  = 32'h0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req_ready) begin
        lat = k;
        rd  = bus.mem_req_data;
        break;
      end
    end
    check("stable_data", rd, 32'h1111_2222);
    check("stable_lat", lat, 32'd4);
    do_req(32'h0000_000C, 1'b0, 32'h0, rd, re, lat);
    check("stable_nowrite", rd, 32'h0);

    // back-to-back with valid held high
    @(negedge clk);
    bus.mem_req_addr  = 32'h0000_0040;
    bus.mem_req_wr    = 1'b0;
    bus.mem_req_valid = 1'b1;
    @(posedge clk);
    n_rdy = 0;
    t_rdy[0] = -1; t_rdy[1] = -1;
    d_rdy[0] = 32'h0; d_rdy[1] = 32'h0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req_ready) begin
        t_rdy[n_rdy] = k;
        d_rdy[n_rdy] = bus.mem_req_data;
        n_rdy++;
        if (n_rdy == 1) bus.mem_req_addr = 32'h0000_0008;
        else begin
          bus.mem_req_valid = 1'b0;
          break;
        end
      end
    end
    check("b2b_first_t", t_rdy[0], 32'd4);
    check("b2b_second_t", t_rdy[1], 32'd10);
    check("b2b_first_d", d_rdy[0], 32'hCAFE_F00D);
    check("b2b_second_d", d_rdy[1], 32'h1111_2222);
    @(posedge clk);
    #1;
    check("b2b_idle", {30'b0, dbg_state}, 32'h0);

    // LATENCY=1 instance
    @(negedge clk);
    bus1.mem_req_addr  = 32'h0000_0040;
    bus1.mem_req_wr    = 1'b1;
    bus1.mem_wr_data   = 32'hA5A5_A5A5;
    bus1.mem_req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus1.mem_req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("lat1_wr_ready", {31'b0, bus1.mem_req_ready}, 32'h1);
    check("lat1_wr_echo", bus1.mem_req_data, 32'hA5A5_A5A5);
    @(negedge clk);
    bus1.mem_req_wr    = 1'b0;
    bus1.mem_req_valid = 1'b1;
    @(posedge clk);
    #1;
    check("lat1_resp_drop", {31'b0, bus1.mem_req_ready}, 32'h0);
    @(posedge clk);
    #1;
    bus1.mem_req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("lat1_rd_ready", {31'b0, bus1.mem_req_ready}, 32'h1);
    check("lat1_rd_data", bus1.mem_req_data, 32'hA5A5_A5A5);

    // reset two cycles into BUSY drops a pending write
    @(negedge clk);
    bus.mem_req_addr  = 32'h0000_0020;
    bus.mem_req_wr    = 1'b1;
    bus.mem_wr_data   = 32'h1234_5678;
    bus.mem_req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_rdy = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req_ready) n_rdy++;
    end
    check("rstbusy_noready", n_rdy, 32'd0);
    do_req(32'h0000_0020, 1'b0, 32'h0, rd, re, lat);
    check("rstbusy_nowrite", rd, 32'h0);

    // reset during RESP keeps the committed write
    @(negedge clk);
    bus.mem_req_addr  = 32'h0000_0024;
    bus.mem_req_wr    = 1'b1;
    bus.mem_wr_data   = 32'h0000_0077;
    bus.mem_req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_req_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req_ready) begin
        lat = k;
        break;
      end
    end
    check("rstresp_lat", lat, 32'd4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstresp_drop", {31'b0, bus.mem_req_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_req(32'h0000_0024, 1'b0, 32'h0, rd, re, lat);
    check("rstresp_kept", rd, 32'h0000_0077);

    // out-of-range / alias
    do_req(32'h0000_1004, 1'b1, 32'h5555_AAAA, rd, re, lat);
    check("alias_wr_lat", lat, 32'd4);
`ifdef MEM_RANGE_CHK_EN
    check("range_wr_err", {31'b0, re}, 32'h1);
    do_req(32'h0000_0004, 1'b0, 32'h0, rd, re, lat);
    check("range_word1_data", rd, 32'h0);
    check("range_word1_err", {31'b0, re}, 32'h0);
    do_req(32'h0000_1004, 1'b0, 32'h0, rd, re, lat);
    check("range_rd_data", rd, 32'h0);
    check("range_rd_err", {31'b0, re}, 32'h1);
`else
    check("alias_wr_err", {31'b0, re}, 32'h0);
    check("alias_wr_echo", rd, 32'h5555_AAAA);
    do_req(32'h0000_0004, 1'b0, 32'h0, rd, re, lat);
    check("alias_word1_data", rd, 32'h5555_AAAA);
    check("alias_word1_err", {31'b0, re}, 32'h0);
    do_req(32'h0000_1004, 1'b0, 32'h0, rd, re, lat);
    check("alias_hi_data", rd, 32'h5555_AAAA);
`endif

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
